// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract unit that sequences one 4-bit carry-lookahead slice over NIB cycles.
// Result is valid NIB+1 cycles after accept; held in DONE until out_ready_i; no accept/result overlap.
module nibble_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s    = p ^ c;
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nxt;
  logic             cy_q;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       s_nib;
  logic             c_out;
  logic             last;

  assign last  = (k == KW'(NIB - 1));
  assign a_nib = a_q[{k, 2'b00} +: 4];
  assign b_nib = b_q[{k, 2'b00} +: 4];

  nibble_cla4 u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .ci (cy_q),
    .s  (s_nib),
    .co (c_out)
  );

  always_comb begin
    res_nxt = res_q;
    res_nxt[{k, 2'b00} +: 4] = s_nib;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k          <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      cy_q       <= 1'b0;
      sum_o      <= '0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            // Subtraction is A + ~B + ~borrow, so B is stored inverted.
            a_q  <= a_i;
            b_q  <= sub_i ? ~b_i : b_i;
            cy_q <= carry_i ^ sub_i;
            k    <= '0;
          end
        end
        RUN: begin
          res_q <= res_nxt;
          cy_q  <= c_out;
          k     <= k + KW'(1);
          if (last) begin
            sum_o      <= res_nxt;
            carry_o    <= c_out;
            overflow_o <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (s_nib[3] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed vector table, back-pressure and mid-run reset
// sequences, then randomized operations against an integer-arithmetic reference model.
module tb_nibble_serial_adder;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             carry_i;
  logic             sub_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             overflow_o;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .carry_i     (carry_i),
    .sub_i       (sub_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sum_o       (sum_o),
    .carry_o     (carry_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic        s;
    logic [15:0] sum;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic, no nibble sequencing.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                       output logic [15:0] sum, output logic co, output logic ov);
    longint ua, ub, t, r;
    ua = longint'(a);
    ub = longint'(b);
    r  = s ? (longint'($signed(a)) - longint'($signed(b)) - longint'(c))
           : (longint'($signed(a)) + longint'($signed(b)) + longint'(c));
    if (s) begin
      t  = ua - ub - longint'(c);
      co = (t >= 0);
    end else begin
      t  = ua + ub + longint'(c);
      co = t[16];
    end
    sum = t[15:0];
    ov  = (r > 32767) || (r < -32768);
  endtask

  // Issue one op, scramble inputs during RUN, hold DONE for 'hold' cycles, then retire it.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                        input int hold, output logic [15:0] rs, output logic rc, output logic ro);
    int n;
    logic [15:0] held;
    rs = '0; rc = 1'b0; ro = 1'b0;
    @(negedge clk_i);
    check("in_ready_idle", {31'b0, in_ready_o}, 32'd1);
    a_i = a; b_i = b; carry_i = c; sub_i = s; in_valid_i = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge clk_i);
      n++;
      if (out_valid_o) break;
      check("in_ready_run", {31'b0, in_ready_o}, 32'd0);
      a_i = 16'($urandom); b_i = 16'($urandom);
      carry_i = 1'($urandom); sub_i = 1'($urandom); in_valid_i = 1'($urandom);
    end
    in_valid_i = 1'b0;
    check("latency", n, NIB + 1);
    if (!out_valid_o) return;
    check("in_ready_done", {31'b0, in_ready_o}, 32'd0);
    held = sum_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check("bp_valid", {31'b0, out_valid_o}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready_o}, 32'd0);
      check("bp_sum_stable", {16'b0, sum_o}, {16'b0, held});
    end
    rs = sum_o; rc = carry_o; ro = overflow_o;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check("retire_valid", {31'b0, out_valid_o}, 32'd0);
    check("retire_in_ready", {31'b0, in_ready_o}, 32'd1);
    check("retire_sum_held", {16'b0, sum_o}, {16'b0, rs});
    check("retire_carry_held", {31'b0, carry_o}, {31'b0, rc});
    check("retire_ovf_held", {31'b0, overflow_o}, {31'b0, ro});
  endtask

  initial begin
    logic [15:0] rs, es;
    logic rc, ro, ec, eo;
    int spurious;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    a_i = '0; b_i = '0; carry_i = 1'b0; sub_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_in_ready", {31'b0, in_ready_o}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
    check("rst_sum", {16'b0, sum_o}, 32'd0);
    check("rst_carry", {31'b0, carry_o}, 32'd0);
    check("rst_ovf", {31'b0, overflow_o}, 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, (i == 0) ? 10 : 1, rs, rc, ro);
      check($sformatf("vec%0d_sum", i), {16'b0, rs}, {16'b0, tbl[i].sum});
      check($sformatf("vec%0d_carry", i), {31'b0, rc}, {31'b0, tbl[i].co});
      check($sformatf("vec%0d_ovf", i), {31'b0, ro}, {31'b0, tbl[i].ov});
    end

    // Reset asserted during RUN step k=2 must discard the operation.
    @(negedge clk_i);
    a_i = 16'h1111; b_i = 16'h2222; carry_i = 1'b0; sub_i = 1'b0; in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_in_ready", {31'b0, in_ready_o}, 32'd1);
    check("midrst_out_valid", {31'b0, out_valid_o}, 32'd0);
    check("midrst_sum", {16'b0, sum_o}, 32'd0);
    check("midrst_carry", {31'b0, carry_o}, 32'd0);
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (out_valid_o) spurious++;
    end
    check("midrst_no_result", spurious, 0);
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 0, rs, rc, ro);
    check("post_rst_sum", {16'b0, rs}, 32'h3333);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic rcin, rsub;
      ra = 16'($urandom); rb = 16'($urandom);
      rcin = 1'($urandom); rsub = 1'($urandom);
      if (i < 4) begin
        ra = (i < 2) ? 16'h7FFF : 16'h8000;
        rb = 16'($urandom_range(0, 3));
      end
      model(ra, rb, rcin, rsub, es, ec, eo);
      run_op(ra, rb, rcin, rsub, int'($urandom_range(0, 2)), rs, rc, ro);
      check("rand_sum", {16'b0, rs}, {16'b0, es});
      check("rand_carry", {31'b0, rc}, {31'b0, ec});
      check("rand_ovf", {31'b0, ro}, {31'b0, eo});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
